// File: rtl/reorder_buffer_pkg.sv
// ============================================================================
// Module  : reorder_buffer_pkg
// Brief   : Shared ROB entry type and sizing constants for ROB, rename, decode.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package reorder_buffer_pkg;

   localparam int c_ROB_COUNT  = 32;
   localparam int c_DATA_WIDTH = 32;
   localparam int c_ARF_IDX_W  = 5;
   localparam int c_ROB_IDX_W  = $clog2(c_ROB_COUNT);

   typedef struct packed {
      logic                    valid;
      logic                    done;
      logic [c_ARF_IDX_W-1:0]  arf_ptr;
      logic [c_DATA_WIDTH-1:0] data;
   } rob_entry_t;

endpackage : reorder_buffer_pkg

`default_nettype wire

// File: rtl/reorder_buffer.sv
// ============================================================================
// Module  : reorder_buffer
// Brief   : In-order retire buffer with out-of-order writeback and flush.
//           Optional macro ROB_WB_BYPASS_EN forwards writeback to the read port.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int ROB_COUNT  = c_ROB_COUNT,
   parameter int DATA_WIDTH = c_DATA_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          alloc_valid_i,
   input  logic [c_ARF_IDX_W-1:0]        alloc_arf_ptr_i,
   output logic                          alloc_ready_o,
   output logic [$clog2(ROB_COUNT)-1:0]  alloc_rob_ptr_o,
   input  logic                          wb_en_i,
   input  logic [$clog2(ROB_COUNT)-1:0]  wb_rob_ptr_i,
   input  logic [DATA_WIDTH-1:0]         wb_data_i,
   input  logic [$clog2(ROB_COUNT)-1:0]  rd_rob_ptr_i,
   output logic [DATA_WIDTH-1:0]         rd_data_o,
   output logic                          rd_done_o,
   output logic                          commit_en_o,
   input  logic                          commit_ready_i,
   output logic [c_ARF_IDX_W-1:0]        commit_arf_ptr_o,
   output logic [$clog2(ROB_COUNT)-1:0]  commit_rob_ptr_o,
   output logic [DATA_WIDTH-1:0]         commit_data_o,
   input  logic                          flush_i,
   output logic [$clog2(ROB_COUNT):0]    count_o
);

   localparam int PW = $clog2(ROB_COUNT);
   localparam logic [PW:0] c_PTR_ONE = {{PW{1'b0}}, 1'b1};

   logic [PW:0]            r_head;
   logic [PW:0]            r_tail;
   logic [ROB_COUNT-1:0]   r_valid;
   logic [ROB_COUNT-1:0]   r_done;
   logic [c_ARF_IDX_W-1:0] r_arf  [ROB_COUNT];
   logic [DATA_WIDTH-1:0]  r_data [ROB_COUNT];

   logic [PW-1:0] w_head_idx;
   logic [PW-1:0] w_tail_idx;
   logic          w_empty;
   logic          w_full;
   logic          w_alloc;
   logic          w_commit;
   logic          w_wb_hit;

   assign w_head_idx = r_head[PW-1:0];
   assign w_tail_idx = r_tail[PW-1:0];
   assign w_empty    = (r_head == r_tail);
   assign w_full     = (r_head[PW] != r_tail[PW]) && (w_head_idx == w_tail_idx);
   assign w_alloc    = alloc_valid_i && !w_full;
   assign w_wb_hit   = wb_en_i && r_valid[wb_rob_ptr_i];

   assign commit_en_o      = !w_empty && r_valid[w_head_idx] && r_done[w_head_idx];
   assign w_commit         = commit_en_o && commit_ready_i;
   assign commit_arf_ptr_o = r_arf[w_head_idx];
   assign commit_rob_ptr_o = w_head_idx;
   assign commit_data_o    = r_data[w_head_idx];

   assign alloc_ready_o   = !w_full;
   assign alloc_rob_ptr_o = w_tail_idx;
   assign count_o         = r_tail - r_head;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_valid <= '0;
         r_done  <= '0;
         for (int i = 0; i < ROB_COUNT; i++) begin
            r_arf[i]  <= '0;
            r_data[i] <= '0;
         end
      end else if (flush_i) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_valid <= '0;
         r_done  <= '0;
      end else begin
         if (w_wb_hit) begin
            r_done[wb_rob_ptr_i] <= 1'b1;
            r_data[wb_rob_ptr_i] <= wb_data_i;
         end
         if (w_commit) begin
            r_valid[w_head_idx] <= 1'b0;
            r_head              <= r_head + c_PTR_ONE;
         end
         // The tail slot is never valid while not full, so it cannot collide
         // with a same-cycle writeback or commit.
         if (w_alloc) begin
            r_valid[w_tail_idx] <= 1'b1;
            r_done[w_tail_idx]  <= 1'b0;
            r_arf[w_tail_idx]   <= alloc_arf_ptr_i;
            r_tail              <= r_tail + c_PTR_ONE;
         end
      end
   end

   always_comb begin
      rd_data_o = r_data[rd_rob_ptr_i];
      rd_done_o = r_done[rd_rob_ptr_i];
`ifdef ROB_WB_BYPASS_EN
      if (w_wb_hit && (wb_rob_ptr_i == rd_rob_ptr_i)) begin
         rd_data_o = wb_data_i;
         rd_done_o = 1'b1;
      end
`endif
   end

endmodule : reorder_buffer

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
// ============================================================================
// Module  : tb_reorder_buffer
// Brief   : Self-checking bench for reorder_buffer against an in-order queue model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reorder_buffer;

   localparam int RC = 32;
   localparam int DW = 32;
   localparam int PW = 5;

   logic          clk;
   logic          rst_n;
   logic          alloc_valid_i;
   logic [4:0]    alloc_arf_ptr_i;
   logic          alloc_ready_o;
   logic [PW-1:0] alloc_rob_ptr_o;
   logic          wb_en_i;
   logic [PW-1:0] wb_rob_ptr_i;
   logic [DW-1:0] wb_data_i;
   logic [PW-1:0] rd_rob_ptr_i;
   logic [DW-1:0] rd_data_o;
   logic          rd_done_o;
   logic          commit_en_o;
   logic          commit_ready_i;
   logic [4:0]    commit_arf_ptr_o;
   logic [PW-1:0] commit_rob_ptr_o;
   logic [DW-1:0] commit_data_o;
   logic          flush_i;
   logic [PW:0]   count_o;

   int checks = 0;
   int errors = 0;

   // Model: program-order queue of live instructions; slot of q[i] is (m_head+i)%RC.
   typedef struct {
      logic [4:0]    arf;
      logic [DW-1:0] data;
      bit            done;
   } ment_t;
   ment_t q[$];
   int    m_head = 0;

   reorder_buffer #(.ROB_COUNT(RC), .DATA_WIDTH(DW)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .alloc_valid_i    (alloc_valid_i),
      .alloc_arf_ptr_i  (alloc_arf_ptr_i),
      .alloc_ready_o    (alloc_ready_o),
      .alloc_rob_ptr_o  (alloc_rob_ptr_o),
      .wb_en_i          (wb_en_i),
      .wb_rob_ptr_i     (wb_rob_ptr_i),
      .wb_data_i        (wb_data_i),
      .rd_rob_ptr_i     (rd_rob_ptr_i),
      .rd_data_o        (rd_data_o),
      .rd_done_o        (rd_done_o),
      .commit_en_o      (commit_en_o),
      .commit_ready_i   (commit_ready_i),
      .commit_arf_ptr_o (commit_arf_ptr_o),
      .commit_rob_ptr_o (commit_rob_ptr_o),
      .commit_data_o    (commit_data_o),
      .flush_i          (flush_i),
      .count_o          (count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive_idle();
      alloc_valid_i   = 1'b0;
      alloc_arf_ptr_i = '0;
      wb_en_i         = 1'b0;
      wb_rob_ptr_i    = '0;
      wb_data_i       = '0;
      rd_rob_ptr_i    = '0;
      commit_ready_i  = 1'b0;
      flush_i         = 1'b0;
   endtask

   function automatic int find_slot(input int slot);
      for (int i = 0; i < q.size(); i++)
         if (((m_head + i) % RC) == slot) return i;
      return -1;
   endfunction

   // Advance the model by one clock using the inputs currently applied, then
   // return at the following negedge.
   task automatic step();
      bit            com;
      bit            alc;
      int            wi;
      logic [4:0]    arf;
      logic [DW-1:0] d;
      bit            fl;
      ment_t         e;
      com = (q.size() > 0) && q[0].done && commit_ready_i;
      alc = alloc_valid_i && (q.size() < RC);
      wi  = wb_en_i ? find_slot(int'(wb_rob_ptr_i)) : -1;
      arf = alloc_arf_ptr_i;
      d   = wb_data_i;
      fl  = flush_i;
      @(posedge clk);
      if (fl) begin
         q.delete();
         m_head = 0;
      end else begin
         if (wi >= 0) begin
            e = q[wi]; e.done = 1'b1; e.data = d; q[wi] = e;
         end
         if (com) begin
            void'(q.pop_front());
            m_head = (m_head + 1) % RC;
         end
         if (alc) begin
            e.arf = arf; e.data = '0; e.done = 1'b0;
            q.push_back(e);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive_idle();
      #12;
      checks++; if (alloc_ready_o !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready got %b exp 1", alloc_ready_o); end
      checks++; if (alloc_rob_ptr_o !== '0) begin errors++; $display("FAIL reset_alloc_ptr got %0d exp 0", alloc_rob_ptr_o); end
      checks++; if (commit_en_o !== 1'b0) begin errors++; $display("FAIL reset_commit_en got %b exp 0", commit_en_o); end
      checks++; if (count_o !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
      checks++; if (rd_done_o !== 1'b0) begin errors++; $display("FAIL reset_rd_done got %b exp 0", rd_done_o); end
      checks++; if (commit_data_o !== '0) begin errors++; $display("FAIL reset_commit_data got %h exp 0", commit_data_o); end
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      m_head = 0;
   endtask

   task automatic test_alloc_commit_order();
      for (int i = 0; i < 3; i++) begin
         alloc_valid_i = 1'b1; alloc_arf_ptr_i = 5'(5 + i);
         #1;
         checks++; if (alloc_rob_ptr_o !== PW'(i)) begin errors++; $display("FAIL alloc_ptr got %0d exp %0d", alloc_rob_ptr_o, i); end
         step();
      end
      drive_idle();
      #1;
      checks++; if (count_o !== 6'd3) begin errors++; $display("FAIL alloc_count got %0d exp 3", count_o); end
      checks++; if (commit_en_o !== 1'b0) begin errors++; $display("FAIL alloc_commit_en got %b exp 0", commit_en_o); end
      wb_en_i = 1'b1; wb_rob_ptr_i = 5'd1; wb_data_i = 32'hA;
      step();
      checks++; if (commit_en_o !== 1'b0) begin errors++; $display("FAIL ooo_wb_commit_en got %b exp 0", commit_en_o); end
      wb_rob_ptr_i = 5'd0; wb_data_i = 32'hB;
      step();
      drive_idle();
      commit_ready_i = 1'b1;
      #1;
      checks++; if ({commit_en_o, commit_rob_ptr_o, commit_data_o, commit_arf_ptr_o} !== {1'b1, 5'd0, 32'hB, 5'd5})
         begin errors++; $display("FAIL commit0 got en=%b ptr=%0d data=%h arf=%0d exp 1/0/b/5", commit_en_o, commit_rob_ptr_o, commit_data_o, commit_arf_ptr_o); end
      step();
      #1;
      checks++; if ({commit_en_o, commit_rob_ptr_o, commit_data_o, commit_arf_ptr_o} !== {1'b1, 5'd1, 32'hA, 5'd6})
         begin errors++; $display("FAIL commit1 got en=%b ptr=%0d data=%h arf=%0d exp 1/1/a/6", commit_en_o, commit_rob_ptr_o, commit_data_o, commit_arf_ptr_o); end
      step();
      #1;
      checks++; if (commit_en_o !== 1'b0 || count_o !== 6'd1) begin errors++; $display("FAIL commit_blocked got en=%b count=%0d exp 0/1", commit_en_o, count_o); end
      drive_idle();
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
   endtask

   task automatic test_full_wrap();
      for (int i = 0; i < RC; i++) begin
         alloc_valid_i = 1'b1; alloc_arf_ptr_i = 5'(i);
         #1;
         checks++; if (alloc_rob_ptr_o !== PW'(i)) begin errors++; $display("FAIL fill_ptr got %0d exp %0d", alloc_rob_ptr_o, i); end
         step();
      end
      alloc_valid_i = 1'b0;
      #1;
      checks++; if (alloc_ready_o !== 1'b0 || count_o !== 6'd32) begin errors++; $display("FAIL full got ready=%b count=%0d exp 0/32", alloc_ready_o, count_o); end
      wb_en_i = 1'b1; wb_rob_ptr_i = 5'd0; wb_data_i = 32'h1234;
      step();
      wb_en_i = 1'b0; commit_ready_i = 1'b1; alloc_valid_i = 1'b1;
      #1;
      checks++; if (commit_en_o !== 1'b1 || alloc_ready_o !== 1'b0) begin errors++; $display("FAIL full_commit got en=%b ready=%b exp 1/0", commit_en_o, alloc_ready_o); end
      step();
      commit_ready_i = 1'b0; alloc_valid_i = 1'b0;
      #1;
      checks++; if ({alloc_ready_o, alloc_rob_ptr_o, count_o} !== {1'b1, 5'd0, 6'd31})
         begin errors++; $display("FAIL wrap got ready=%b ptr=%0d count=%0d exp 1/0/31", alloc_ready_o, alloc_rob_ptr_o, count_o); end
   endtask

   task automatic test_backpressure();
      wb_en_i = 1'b1; wb_rob_ptr_i = 5'd1; wb_data_i = 32'h77;
      step();
      wb_en_i = 1'b0; commit_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (commit_en_o !== 1'b1 || commit_rob_ptr_o !== 5'd1) begin errors++; $display("FAIL hold got en=%b ptr=%0d exp 1/1", commit_en_o, commit_rob_ptr_o); end
         step();
      end
      commit_ready_i = 1'b1;
      #1;
      checks++; if (commit_data_o !== 32'h77) begin errors++; $display("FAIL release_data got %h exp 77", commit_data_o); end
      step();
      commit_ready_i = 1'b0;
      #1;
      checks++; if ({count_o, commit_en_o, commit_rob_ptr_o} !== {6'd30, 1'b0, 5'd2})
         begin errors++; $display("FAIL single_commit got count=%0d en=%b ptr=%0d exp 30/0/2", count_o, commit_en_o, commit_rob_ptr_o); end
   endtask

   task automatic test_flush();
      wb_en_i = 1'b1; wb_rob_ptr_i = 5'd2; wb_data_i = 32'h99;
      step();
      flush_i = 1'b1; alloc_valid_i = 1'b1; commit_ready_i = 1'b1;
      wb_rob_ptr_i = 5'd3; wb_data_i = 32'h42;
      step();
      drive_idle();
      #1;
      checks++; if ({count_o, commit_en_o, alloc_rob_ptr_o, alloc_ready_o} !== {6'd0, 1'b0, 5'd0, 1'b1})
         begin errors++; $display("FAIL flush got count=%0d en=%b ptr=%0d ready=%b exp 0/0/0/1", count_o, commit_en_o, alloc_rob_ptr_o, alloc_ready_o); end
   endtask

   task automatic test_bypass();
      alloc_valid_i = 1'b1; alloc_arf_ptr_i = 5'd3;
      step();
      drive_idle();
      wb_en_i = 1'b1; wb_rob_ptr_i = 5'd0; wb_data_i = 32'h55; rd_rob_ptr_i = 5'd0;
      #1;
`ifdef ROB_WB_BYPASS_EN
      checks++; if (rd_done_o !== 1'b1 || rd_data_o !== 32'h55) begin errors++; $display("FAIL bypass got done=%b data=%h exp 1/55", rd_done_o, rd_data_o); end
`else
      checks++; if (rd_done_o !== 1'b0) begin errors++; $display("FAIL no_bypass got done=%b exp 0", rd_done_o); end
`endif
      step();
      wb_en_i = 1'b0;
      #1;
      checks++; if (rd_done_o !== 1'b1 || rd_data_o !== 32'h55) begin errors++; $display("FAIL rd_after_wb got done=%b data=%h exp 1/55", rd_done_o, rd_data_o); end
   endtask

   task automatic test_random();
      int            ri;
      logic          e_done;
      logic [DW-1:0] e_data;
      logic [PW-1:0] e_ptr;
      for (int n = 0; n < 3000; n++) begin
         alloc_valid_i   = ($urandom_range(0, 99) < 60);
         alloc_arf_ptr_i = 5'($urandom);
         wb_en_i         = ($urandom_range(0, 99) < 50);
         wb_rob_ptr_i    = (q.size() > 0 && $urandom_range(0, 3) != 0)
                           ? PW'((m_head + $urandom_range(0, q.size() - 1)) % RC) : PW'($urandom);
         wb_data_i       = $urandom;
         rd_rob_ptr_i    = ($urandom_range(0, 1) == 1) ? wb_rob_ptr_i : PW'($urandom);
         commit_ready_i  = ($urandom_range(0, 99) < 70);
         flush_i         = ($urandom_range(0, 99) == 0);
         #1;
         e_ptr = PW'((m_head + q.size()) % RC);
         checks++; if (count_o !== (PW + 1)'(q.size())) begin errors++; $display("FAIL rnd_count n=%0d got %0d exp %0d", n, count_o, q.size()); end
         checks++; if (alloc_ready_o !== (q.size() < RC)) begin errors++; $display("FAIL rnd_ready n=%0d got %b exp %b", n, alloc_ready_o, q.size() < RC); end
         checks++; if (alloc_rob_ptr_o !== e_ptr) begin errors++; $display("FAIL rnd_alloc_ptr n=%0d got %0d exp %0d", n, alloc_rob_ptr_o, e_ptr); end
         e_done = (q.size() > 0) && q[0].done;
         checks++; if (commit_en_o !== e_done) begin errors++; $display("FAIL rnd_commit_en n=%0d got %b exp %b", n, commit_en_o, e_done); end
         if (e_done) begin
            checks++;
            if (commit_rob_ptr_o !== PW'(m_head) || commit_data_o !== q[0].data || commit_arf_ptr_o !== q[0].arf) begin
               errors++;
               $display("FAIL rnd_commit n=%0d got ptr=%0d data=%h arf=%0d exp %0d/%h/%0d",
                        n, commit_rob_ptr_o, commit_data_o, commit_arf_ptr_o, m_head, q[0].data, q[0].arf);
            end
         end
         ri = find_slot(int'(rd_rob_ptr_i));
         if (ri >= 0) begin
            e_done = q[ri].done;
            e_data = q[ri].data;
`ifdef ROB_WB_BYPASS_EN
            if (wb_en_i && wb_rob_ptr_i == rd_rob_ptr_i) begin
               e_done = 1'b1;
               e_data = wb_data_i;
            end
`endif
            checks++; if (rd_done_o !== e_done) begin errors++; $display("FAIL rnd_rd_done n=%0d got %b exp %b", n, rd_done_o, e_done); end
            if (e_done) begin
               checks++; if (rd_data_o !== e_data) begin errors++; $display("FAIL rnd_rd_data n=%0d got %h exp %h", n, rd_data_o, e_data); end
            end
         end
         step();
      end
      drive_idle();
   endtask

   task automatic test_reset_midop();
      flush_i = 1'b1;
      step();
      drive_idle();
      alloc_valid_i = 1'b1; alloc_arf_ptr_i = 5'd9;
      step();
      step();
      drive_idle();
      wb_en_i = 1'b1; wb_rob_ptr_i = 5'd0; wb_data_i = 32'hCAFE;
      step();
      drive_idle();
      commit_ready_i = 1'b1;
      #1;
      checks++; if (commit_en_o !== 1'b1 || count_o !== 6'd2) begin errors++; $display("FAIL pre_reset got en=%b count=%0d exp 1/2", commit_en_o, count_o); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if ({commit_en_o, count_o, alloc_ready_o, commit_data_o} !== {1'b0, 6'd0, 1'b1, 32'h0})
         begin errors++; $display("FAIL midop_reset got en=%b count=%0d ready=%b data=%h exp 0/0/1/0", commit_en_o, count_o, alloc_ready_o, commit_data_o); end
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      m_head = 0;
      step();
      #1;
      checks++; if (count_o !== '0 || commit_en_o !== 1'b0) begin errors++; $display("FAIL post_reset got count=%0d en=%b exp 0/0", count_o, commit_en_o); end
      drive_idle();
   endtask

   initial begin
      test_reset();
      test_alloc_commit_order();
      test_full_wrap();
      test_backpressure();
      test_flush();
      test_bypass();
      test_random();
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_reorder_buffer

`default_nettype wire
